// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDR SDRAM power-up/init sequencer gated by a qualified PLL lock
module sdram_init_seq #(
    parameter int          LOCK_FILTER = 1024,
    parameter int          POWERUP_CYC = 20000,
    parameter int          T_RP        = 2,
    parameter int          T_RFC       = 7,
    parameter int          T_MRD       = 2,
    parameter int          NUM_REF     = 2,
    parameter logic [12:0] MODE_REG    = 13'h033
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pll_lock,
    output logic        o_sdram_cke,
    output logic        o_sdram_cs_n,
    output logic        o_sdram_ras_n,
    output logic        o_sdram_cas_n,
    output logic        o_sdram_we_n,
    output logic [1:0]  o_sdram_ba,
    output logic [12:0] o_sdram_addr,
    output logic        o_init_done,
    output logic        o_lock_lost
);
    localparam int FW   = $clog2(LOCK_FILTER);
    localparam int DM1  = (POWERUP_CYC > T_RFC) ? POWERUP_CYC : T_RFC;
    localparam int DM2  = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int DMAX = (DM1 > DM2) ? DM1 : DM2;
    localparam int DW   = $clog2(DMAX + 1);
    localparam int RW   = $clog2(NUM_REF + 1);

    typedef enum logic [3:0] {
        S_WAIT_LOCK, S_POWERUP, S_PRE, S_WAIT_RP, S_REF,
        S_WAIT_RFC, S_MRS, S_WAIT_MRD, S_DONE
    } state_t;

    state_t        r_state, w_state;
    logic [1:0]    r_sync;
    logic [FW-1:0] r_fcnt, w_fcnt;
    logic [DW-1:0] r_dcnt, w_dcnt;
    logic [RW-1:0] r_rcnt, w_rcnt;
    logic          w_lost, w_lock_s, w_dly_end;
    logic [3:0]    w_cmd;
    logic [12:0]   w_addr;

    assign w_lock_s   = r_sync[1];
    assign w_dly_end  = r_dcnt == DW'(1);
    assign o_sdram_ba = 2'b00;

    // Sequencing: delays are loaded when a command state is entered and count down to 1
    always_comb begin
        w_state = r_state;
        w_fcnt  = r_fcnt;
        w_dcnt  = r_dcnt;
        w_rcnt  = r_rcnt;
        w_lost  = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                if (!w_lock_s) begin
                    w_fcnt = '0;
                end else if (r_fcnt == FW'(LOCK_FILTER - 1)) begin
                    w_state = S_POWERUP;
                    w_fcnt  = '0;
                    w_dcnt  = DW'(POWERUP_CYC);
                end else begin
                    w_fcnt = r_fcnt + FW'(1);
                end
            end
            S_POWERUP: begin
                if (w_dly_end) begin
                    w_state = S_PRE;
                    w_dcnt  = DW'(T_RP);
                end else begin
                    w_dcnt = r_dcnt - DW'(1);
                end
            end
            S_PRE, S_WAIT_RP: begin
                if (w_dly_end) begin
                    w_state = S_REF;
                    w_dcnt  = DW'(T_RFC);
                    w_rcnt  = r_rcnt + RW'(1);
                end else begin
                    w_state = S_WAIT_RP;
                    w_dcnt  = r_dcnt - DW'(1);
                end
            end
            S_REF, S_WAIT_RFC: begin
                if (w_dly_end && r_rcnt < RW'(NUM_REF)) begin
                    w_state = S_REF;
                    w_dcnt  = DW'(T_RFC);
                    w_rcnt  = r_rcnt + RW'(1);
                end else if (w_dly_end) begin
                    w_state = S_MRS;
                    w_dcnt  = DW'(T_MRD);
                end else begin
                    w_state = S_WAIT_RFC;
                    w_dcnt  = r_dcnt - DW'(1);
                end
            end
            S_MRS, S_WAIT_MRD: begin
                if (w_dly_end) begin
                    w_state = S_DONE;
                    w_dcnt  = '0;
                end else begin
                    w_state = S_WAIT_MRD;
                    w_dcnt  = r_dcnt - DW'(1);
                end
            end
            S_DONE: w_state = S_DONE;
            default: w_state = S_WAIT_LOCK;
        endcase
        if (r_state != S_WAIT_LOCK && !w_lock_s) begin
            w_state = S_WAIT_LOCK;
            w_fcnt  = '0;
            w_dcnt  = '0;
            w_rcnt  = '0;
            w_lost  = 1'b1;
        end
    end

    // Bus decode from the state being entered, so each command shows in its state's first cycle
    always_comb begin
        w_cmd  = (w_state == S_WAIT_LOCK) ? 4'b1111 :
                 (w_state == S_PRE)       ? 4'b0010 :
                 (w_state == S_REF)       ? 4'b0001 :
                 (w_state == S_MRS)       ? 4'b0000 : 4'b0111;
        w_addr = (w_state == S_PRE) ? 13'h400 :
                 (w_state == S_MRS) ? MODE_REG : 13'd0;
    end

    // State, counters, lock synchronizer and registered SDRAM bus
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_WAIT_LOCK;
            r_sync       <= 2'b00;
            r_fcnt       <= '0;
            r_dcnt       <= '0;
            r_rcnt       <= '0;
            o_sdram_cke  <= 1'b0;
            {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} <= 4'b1111;
            o_sdram_addr <= 13'd0;
            o_init_done  <= 1'b0;
            o_lock_lost  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_sync       <= {r_sync[0], i_pll_lock};
            r_fcnt       <= w_fcnt;
            r_dcnt       <= w_dcnt;
            r_rcnt       <= w_rcnt;
            o_sdram_cke  <= w_state != S_WAIT_LOCK;
            {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} <= w_cmd;
            o_sdram_addr <= w_addr;
            o_init_done  <= w_state == S_DONE;
            o_lock_lost  <= w_lost;
        end
    end
endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq: timeline-model scoreboard for two sequencer configurations
module tb_sdram_init_seq;
    localparam int LF = 8;
    localparam int PC = 100;

    typedef struct {
        int          inst;
        int          cyc;
        logic [21:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lock = 1'b0;
    logic [1:0]  cke, cs_n, ras_n, cas_n, we_n, done, lost;
    logic [1:0]  ba [2];
    logic [12:0] addr [2];

    int p_rp  [2] = '{2, 1};
    int p_rfc [2] = '{7, 7};
    int p_mrd [2] = '{2, 1};
    int p_nr  [2] = '{2, 1};

    exp_t q[$];
    int   checks = 0, errors = 0, n = 0;
    int   t [2] = '{-1, -1};
    int   h [2] = '{0, 0};
    bit   s1 [2] = '{0, 0};
    bit   s2 [2] = '{0, 0};
    int   rise_cke [2], fall_cke [2], rise_done [2], fall_done [2], rise_lost [2];
    logic [1:0] pv_cke = 2'b00, pv_done = 2'b00, pv_lost = 2'b00;

    always #5 clk = ~clk;

    sdram_init_seq #(.LOCK_FILTER(LF), .POWERUP_CYC(PC)) u0 (
        .i_clk(clk), .i_rst(rst), .i_pll_lock(lock),
        .o_sdram_cke(cke[0]), .o_sdram_cs_n(cs_n[0]), .o_sdram_ras_n(ras_n[0]),
        .o_sdram_cas_n(cas_n[0]), .o_sdram_we_n(we_n[0]), .o_sdram_ba(ba[0]),
        .o_sdram_addr(addr[0]), .o_init_done(done[0]), .o_lock_lost(lost[0])
    );

    sdram_init_seq #(.LOCK_FILTER(LF), .POWERUP_CYC(PC), .T_RP(1), .T_MRD(1), .NUM_REF(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_pll_lock(lock),
        .o_sdram_cke(cke[1]), .o_sdram_cs_n(cs_n[1]), .o_sdram_ras_n(ras_n[1]),
        .o_sdram_cas_n(cas_n[1]), .o_sdram_we_n(we_n[1]), .o_sdram_ba(ba[1]),
        .o_sdram_addr(addr[1]), .o_init_done(done[1]), .o_lock_lost(lost[1])
    );

    // Expected bus given the cycle offset tt from POWERUP entry (negative: waiting for lock)
    function automatic logic [21:0] expv(int i, int tt, bit lst);
        logic [3:0]  c;
        logic [12:0] a;
        int          mrs;
        if (tt < 0) return {1'b0, 4'hF, 2'b00, 13'd0, 1'b0, lst};
        c   = 4'b0111;
        a   = 13'd0;
        mrs = PC + p_rp[i] + p_nr[i] * p_rfc[i];
        if (tt == PC) begin
            c = 4'b0010;
            a = 13'h400;
        end
        for (int k = 1; k <= p_nr[i]; k++)
            if (tt == PC + p_rp[i] + (k - 1) * p_rfc[i]) c = 4'b0001;
        if (tt == mrs) begin
            c = 4'b0000;
            a = 13'h033;
        end
        return {1'b1, c, 2'b00, a, tt >= mrs + p_mrd[i], 1'b0};
    endfunction

    function automatic logic [21:0] actv(int i);
        return {cke[i], cs_n[i], ras_n[i], cas_n[i], we_n[i], ba[i], addr[i], done[i], lost[i]};
    endfunction

    task automatic check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    // One clock: advance the model on the inputs of the elapsed cycle, then drive new inputs
    task automatic step(input bit r, input bit l);
        @(posedge clk);
        n++;
        for (int i = 0; i < 2; i++) begin
            bit lst;
            bit ls;
            lst = 1'b0;
            ls  = s2[i];
            if (rst) begin
                t[i]  = -1;
                h[i]  = 0;
                s1[i] = 1'b0;
                s2[i] = 1'b0;
            end else begin
                s2[i] = s1[i];
                s1[i] = lock;
                if (t[i] >= 0 && !ls) begin
                    t[i] = -1;
                    h[i] = 0;
                    lst  = 1'b1;
                end else if (t[i] >= 0) begin
                    t[i]++;
                end else if (ls) begin
                    h[i]++;
                    if (h[i] == LF) begin
                        t[i] = 0;
                        h[i] = 0;
                    end
                end else begin
                    h[i] = 0;
                end
            end
            q.push_back('{i, n, expv(i, t[i], lst)});
        end
        #1;
        rst  = r;
        lock = l;
    endtask

    // Monitor: compare every presented cycle against the scoreboard and log edge times
    initial forever begin
        exp_t e;
        logic [21:0] a;
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            a = actv(e.inst);
            checks++;
            if (a !== e.v) begin
                errors++;
                $display("FAIL bus u%0d cycle %0d got %h expected %h", e.inst, e.cyc, a, e.v);
            end
            if (cke[e.inst] && !pv_cke[e.inst]) rise_cke[e.inst] = e.cyc;
            if (!cke[e.inst] && pv_cke[e.inst]) fall_cke[e.inst] = e.cyc;
            if (done[e.inst] && !pv_done[e.inst]) rise_done[e.inst] = e.cyc;
            if (!done[e.inst] && pv_done[e.inst]) fall_done[e.inst] = e.cyc;
            if (lost[e.inst] && !pv_lost[e.inst]) rise_lost[e.inst] = e.cyc;
            pv_cke[e.inst]  = cke[e.inst];
            pv_done[e.inst] = done[e.inst];
            pv_lost[e.inst] = lost[e.inst];
        end
    end

    initial begin
        int n0, lr, nf, rl, rr, len;
        bit l;
        repeat (3) step(1, 0);
        // Nominal bring-up
        step(0, 1);
        n0 = n;
        repeat (140) step(0, 1);
        check("nom_cke_rise", rise_cke[0], n0 + 10);
        check("nom_done", rise_done[0], n0 + 128);
        check("short_done", rise_done[1], n0 + 119);
        // Lock loss in DONE
        step(0, 0);
        nf = n;
        repeat (5) step(0, 0);
        check("done_fall", fall_done[0], nf + 3);
        check("done_lost", rise_lost[0], nf + 3);
        // Chatter then steady lock
        lr = n;
        for (int c = 0; c < 100; c++) begin
            step(0, ((c / 5) % 2) == 1);
            if ((c % 10) == 5) lr = n;
        end
        repeat (140) step(0, 1);
        check("chatter_cke_rise", rise_cke[0], lr + 10);
        check("redo_done", rise_done[0], lr + 128);
        // Lock loss 50 cycles into POWERUP
        repeat (5) step(0, 0);
        step(0, 1);
        rl = n;
        repeat (59) step(0, 1);
        step(0, 0);
        nf = n;
        repeat (4) step(0, 0);
        check("pwr_cke_rise", rise_cke[0], rl + 10);
        check("pwr_cke_fall", fall_cke[0], nf + 3);
        check("pwr_lost", rise_lost[0], nf + 3);
        step(0, 1);
        rl = n;
        repeat (140) step(0, 1);
        check("pwr_redo_done", rise_done[0], rl + 128);
        // Reset while refreshing
        repeat (5) step(0, 0);
        step(0, 1);
        rl = n;
        repeat (113) step(0, 1);
        step(1, 1);
        step(0, 1);
        rr = n;
        repeat (30) step(0, 1);
        check("rst_cke_rise", rise_cke[0], rr + 10);
        // Random lock segments with occasional reset
        l = 1'b1;
        while (n < 6000) begin
            l   = !l;
            len = $urandom_range(1, 170);
            for (int k = 0; k < len; k++) step($urandom_range(0, 199) == 0, l);
        end
        repeat (3) step(0, l);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_init_seq.md
# sdram_init_seq

SDRAM power-up and initialization sequencer on the 100 MHz SDRAM PLL clock domain. Watches the PLL `lock` output, qualifies it, then runs the JEDEC SDR init sequence: power-up wait, PRECHARGE ALL, N× AUTO REFRESH, LOAD MODE REGISTER. It then hands the command bus to the SDRAM controller by raising `init_done`. Loss of lock at any point aborts the sequence and restarts it.

## Interface
- `LOCK_FILTER`, 1024: consecutive synchronized-lock-high cycles required before power-up starts (≥2).
- `POWERUP_CYC`, 20000: NOP cycles with CKE high before PRECHARGE (200 µs at 100 MHz).
- `T_RP`, 2: PRECHARGE-to-command spacing in cycles (≥1).
- `T_RFC`, 7: REFRESH-to-command spacing in cycles (≥1).
- `T_MRD`, 2: LOAD MODE to `init_done` in cycles (≥1).
- `NUM_REF`, 2: AUTO REFRESH commands issued (1–15).
- `MODE_REG`, 13'h033: value driven on `sdram_addr` during LOAD MODE (CL3, BL8, sequential).
- `clk` in 1: SDRAM PLL `clkout`, 100 MHz.
- `rst` in 1: synchronous, active-high reset.
- `pll_lock` in 1: PLL lock, asynchronous to `clk`.
- `sdram_cke` out 1: clock enable.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` out 1 each: command.
- `sdram_ba` out 2: bank address.
- `sdram_addr` out 13: address.
- `init_done` out 1: level; high once the sequence completes, while lock holds.
- `lock_lost` out 1: one-cycle pulse when qualified lock drops.

## Operation
- `pll_lock` passes through a 2-FF synchronizer (`lock_s`). Nothing else samples `pll_lock`.
- Commands (cs,ras,cas,we): DESELECT = 1,x,x,x (driven as 1111). NOP = 0111. PRE = 0010 with addr[10]=1, ba=0. REF = 0001. MRS = 0000 with ba=0, addr=MODE_REG. In all other cycles addr=0 and ba=0.
- States: WAIT_LOCK, POWERUP, PRE, WAIT_RP, REF, WAIT_RFC, MRS, WAIT_MRD, DONE.
- WAIT_LOCK: DESELECT, cke=0. Filter counter increments while `lock_s`=1 and clears when `lock_s`=0. At count==LOCK_FILTER, go to POWERUP and clear the counter.
- POWERUP: cke=1, NOP for exactly POWERUP_CYC cycles, then PRE.
- PRE: one cycle. Then WAIT_RP NOPs, so the next command lands exactly T_RP cycles after PRE.
- REF: one cycle, with the refresh counter incremented. WAIT_RFC: NOPs so the next command lands T_RFC cycles later. Next is REF if count<NUM_REF, else MRS.
- MRS: one cycle. After T_MRD cycles, go to DONE. `init_done` asserts in the DONE entry cycle.
- DONE: module drives NOP, cke=1. The controller's own bus muxes on `init_done`.
- Lock loss: `lock_s`=0 in any state other than WAIT_LOCK aborts immediately. Next edge: WAIT_LOCK, cke=0, DESELECT, `init_done`=0, `lock_lost`=1 for one cycle. All counters clear.
- Counters are sized by $clog2 of their parameter and must not wrap. Delay counts are loaded on state entry and count down to 1.

## Timing
- All outputs are registered; a command is visible in the first cycle of its state.
- Reset values, on the first edge with `rst`=1: state WAIT_LOCK, cke=0, cs_n=ras_n=cas_n=we_n=1, ba=0, addr=0, init_done=0, lock_lost=0, synchronizer flops=0, all counters 0. `rst` beats lock loss, and it beats anything else mid-sequence.
- `pll_lock` rise to POWERUP entry: 2 (sync) + LOCK_FILTER cycles.
- Let P be the PRE cycle, which comes POWERUP_CYC cycles after POWERUP entry. Then REF_k = P + T_RP + (k−1)·T_RFC, MRS = P + T_RP + NUM_REF·T_RFC, and init_done = MRS + T_MRD.
- `pll_lock` fall to outputs showing abort: 3 cycles (2 sync + 1 register).
- A lock glitch shorter than one sample can be missed by the synchronizer. That is acceptable.

## Test plan
- Nominal sequence, with LOCK_FILTER=8, POWERUP_CYC=100 and the other parameters at default. Raise lock at cycle 0. Required response:
  - cke rises at cycle 10.
  - PRE (addr[10]=1) at cycle 110.
  - REF at cycles 112 and 119.
  - MRS with addr=13'h033 at cycle 126.
  - init_done at cycle 128. Every other cycle from 10 on is NOP.
- Lock chatter: toggle lock every 5 cycles for 100 cycles. Cke must stay 0 and the bus must stay DESELECT. Then hold lock high; cke rises exactly 10 cycles after the last rise.
- Lock loss mid-POWERUP: drop lock 50 cycles after cke rises. Three cycles later, cke=0 and lock_lost pulses for 1 cycle. On relock, the full sequence reruns with POWERUP_CYC counted from zero.
- Lock loss in DONE: init_done falls and lock_lost pulses, both 3 cycles after lock falls. The sequence then reruns, and the second init_done timing matches the first.
- Reset mid-sequence: assert rst for 1 cycle while in WAIT_RFC. All outputs take reset values on that edge. With lock still high, cke rises 10 cycles after rst is released.
- NUM_REF=1, T_RP=1, T_MRD=1: REF at P+1, MRS at P+8, init_done at P+9.
